// File: rtl/rah_pkt_pkg.sv
`default_nettype none
// ============================================================================
// rah_pkt_pkg : shared header field widths, codes and FSM states for result_packer
// Rev 1.0
// ============================================================================
package rah_pkt_pkg;

    localparam int APP_W  = 2;
    localparam int SIZE_W = 3;
    localparam int BEAT_W = 3;

    localparam logic [BEAT_W-1:0] BEAT_SINGLE = 3'b000;

    localparam logic [APP_W-1:0] APP_INT   = 2'b01;
    localparam logic [APP_W-1:0] APP_FLOAT = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // A zero length still carries one beat; anything longer than the result holds is cut off.
    function automatic logic [BEAT_W-1:0] clamp_len(input logic [BEAT_W-1:0] raw, input int max_beats);
        if (raw == '0) return BEAT_W'(1);
        if (int'(raw) > max_beats) return BEAT_W'(max_beats);
        return raw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin pick, first request at or after ptr
// Rev 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N     = 6,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx
);

    always_comb begin : p_pick
        int  c;
        logic w_found;
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        c       = 0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr) + k;
            if (c >= N) c = c - N;
            if (!w_found && req[c]) begin
                w_found  = 1'b1;
                grant[c] = 1'b1;
                idx      = PTR_W'(c);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/result_packer.sv
`default_nettype none
// ============================================================================
// result_packer : round-robin collection of channel results, serialised into
//                 header-tagged words for the downstream output FIFO
// Rev 1.0
// ============================================================================
module result_packer
    import rah_pkt_pkg::*;
#(
    parameter int NUM_CH    = 6,
    parameter int PAYLOAD_W = 40,
    parameter int RES_W     = 80
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         ch_valid,
    output logic [NUM_CH-1:0]         ch_ready,
    input  logic [NUM_CH*RES_W-1:0]   ch_data,
    input  logic [NUM_CH*APP_W-1:0]   ch_app,
    input  logic [NUM_CH*SIZE_W-1:0]  ch_size,
    input  logic [NUM_CH*BEAT_W-1:0]  ch_len,
    input  logic                      out_full,
    output logic [PAYLOAD_W+7:0]      dout,
    output logic                      dout_wren,
    output logic                      busy,
    output logic [15:0]               pkt_count
);

    localparam int MAX_BEATS = RES_W / PAYLOAD_W;
    localparam int PTR_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t                r_state, w_state_next;
    logic [RES_W-1:0]      r_sr;
    logic [APP_W-1:0]      r_app;
    logic [SIZE_W-1:0]     r_size;
    logic [BEAT_W-1:0]     r_len;
    logic [BEAT_W-1:0]     r_beat;
    logic [PTR_W-1:0]      r_idx;
    logic [PTR_W-1:0]      r_ptr;
    logic [PAYLOAD_W+7:0]  r_dout;
    logic                  r_wren;
    logic [15:0]           r_pkt_count;

    logic [NUM_CH-1:0]     w_req, w_grant;
    logic [PTR_W-1:0]      w_idx;
    logic                  w_hs, w_emit, w_last;
    logic [BEAT_W-1:0]     w_beat_code;

    // Requests are only offered to the arbiter while idle, so ready is naturally 0 in SEND.
    assign w_req    = (r_state == IDLE) ? ch_valid : '0;
    assign ch_ready = rst_n ? w_grant : '0;

    rr_arbiter #(
        .N     (NUM_CH),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (w_req),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx)
    );

    assign w_last      = (r_beat == r_len - BEAT_W'(1));
    assign w_beat_code = (r_len == BEAT_W'(1)) ? BEAT_SINGLE : r_beat + BEAT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_hs         = 1'b0;
        w_emit       = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_grant) begin
                    w_hs         = 1'b1;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                if (!out_full) begin
                    w_emit = 1'b1;
                    if (w_last) w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr        <= '0;
            r_app       <= '0;
            r_size      <= '0;
            r_len       <= '0;
            r_beat      <= '0;
            r_idx       <= '0;
            r_ptr       <= '0;
            r_dout      <= '0;
            r_wren      <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            r_dout <= '0;
            r_wren <= 1'b0;
            if (w_hs) begin
                r_sr   <= ch_data[w_idx*RES_W +: RES_W];
                r_app  <= ch_app[w_idx*APP_W +: APP_W];
                r_size <= ch_size[w_idx*SIZE_W +: SIZE_W];
                r_len  <= clamp_len(ch_len[w_idx*BEAT_W +: BEAT_W], MAX_BEATS);
                r_beat <= '0;
                r_idx  <= w_idx;
            end
            if (w_emit) begin
                r_dout <= {r_app, r_size, w_beat_code, r_sr[RES_W-1 -: PAYLOAD_W]};
                r_wren <= 1'b1;
                r_sr   <= r_sr << PAYLOAD_W;
                r_beat <= r_beat + BEAT_W'(1);
                if (w_last) begin
                    r_pkt_count <= r_pkt_count + 16'd1;
                    r_ptr       <= (r_idx == PTR_W'(NUM_CH-1)) ? '0 : r_idx + 1'b1;
                end
            end
        end
    end

    assign dout      = r_dout;
    assign dout_wren = r_wren;
    assign busy      = (r_state == SEND);
    assign pkt_count = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_result_packer.sv
`default_nettype none
// ============================================================================
// tb_result_packer : vector table, directed corner sequences and randomized
//                    rounds against a packet-level reference model
// Rev 1.0
// ============================================================================
module tb_result_packer;

    localparam int NUM_CH = 6;
    localparam int PW     = 40;
    localparam int RES_W  = 80;
    localparam int OW     = PW + 8;
    localparam int MAXB   = RES_W / PW;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_CH-1:0]        ch_valid = '0;
    logic [NUM_CH-1:0]        ch_ready;
    logic [NUM_CH*RES_W-1:0]  ch_data = '0;
    logic [NUM_CH*2-1:0]      ch_app = '0;
    logic [NUM_CH*3-1:0]      ch_size = '0;
    logic [NUM_CH*3-1:0]      ch_len = '0;
    logic                     out_full = 1'b0;
    logic [OW-1:0]            dout;
    logic                     dout_wren;
    logic                     busy;
    logic [15:0]              pkt_count;

    result_packer #(
        .NUM_CH    (NUM_CH),
        .PAYLOAD_W (PW),
        .RES_W     (RES_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_valid  (ch_valid),
        .ch_ready  (ch_ready),
        .ch_data   (ch_data),
        .ch_app    (ch_app),
        .ch_size   (ch_size),
        .ch_len    (ch_len),
        .out_full  (out_full),
        .dout      (dout),
        .dout_wren (dout_wren),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [OW-1:0] wq[$];
    int            wc[$];
    int            gq[$];
    int            gc[$];
    logic [OW-1:0] eq[$];
    int            eo[$];

    logic [RES_W-1:0] md[NUM_CH];
    logic [1:0]       mapp[NUM_CH];
    logic [2:0]       msize[NUM_CH];
    logic [2:0]       mlen[NUM_CH];
    int               m_ptr = 0;
    int               exp_pkts = 0;

    typedef struct {
        int               ch;
        logic [1:0]       app;
        logic [2:0]       size;
        logic [2:0]       len;
        logic [RES_W-1:0] data;
        int               nw;
        logic [OW-1:0]    w0;
        logic [OW-1:0]    w1;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output and handshake monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (dout_wren) begin
                wq.push_back(dout);
                wc.push_back(cyc);
            end else if (dout != '0) begin
                check("dout_zero_when_no_wren", 64'(dout), 64'd0);
            end
            if (!$onehot0(ch_ready)) check("ch_ready_onehot", 64'(ch_ready), 64'd0);
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_ready[i]) begin
                    gq.push_back(i);
                    gc.push_back(cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        wq.delete(); wc.delete(); gq.delete(); gc.delete();
    endtask

    task automatic arm(input int c, input logic [RES_W-1:0] d, input logic [1:0] a,
                       input logic [2:0] s, input logic [2:0] l);
        md[c] = d; mapp[c] = a; msize[c] = s; mlen[c] = l;
        ch_data[c*RES_W +: RES_W] = d;
        ch_app[c*2 +: 2]          = a;
        ch_size[c*3 +: 3]         = s;
        ch_len[c*3 +: 3]          = l;
        ch_valid[c]               = 1'b1;
    endtask

    // Expected words for one packet: top b*PW bits of the result, header prepended.
    function automatic void push_exp(input int c);
        int l;
        logic [RES_W-1:0] top;
        if (mlen[c] == 3'd0)          l = 1;
        else if (int'(mlen[c]) > MAXB) l = MAXB;
        else                           l = int'(mlen[c]);
        for (int b = 1; b <= l; b++) begin
            top = md[c] >> (RES_W - b*PW);
            eq.push_back({mapp[c], msize[c], (l == 1) ? 3'd0 : 3'(b), top[PW-1:0]});
        end
    endfunction

    // Expected service order: first requester at or after the pointer, pointer moves past it.
    function automatic void model_order(input logic [NUM_CH-1:0] mask, input int n, input bit clear);
        int g;
        eo.delete();
        for (int k = 0; k < n; k++) begin
            g = -1;
            for (int j = 0; j < NUM_CH; j++) begin
                if (g < 0 && mask[(m_ptr + j) % NUM_CH]) g = (m_ptr + j) % NUM_CH;
            end
            if (g < 0) break;
            eo.push_back(g);
            if (clear) mask[g] = 1'b0;
            m_ptr = (g + 1) % NUM_CH;
        end
    endfunction

    // Play producer: drop valid after each handshake (unless held), optional random backpressure.
    task automatic serve(input int n, input bit hold, input bit rnd_full);
        int got = 0;
        int left = 3000;
        logic [NUM_CH-1:0] r;
        while (got < n && left > 0) begin
            @(negedge clk);
            r = ch_ready;
            step();
            left--;
            if (r != '0) begin
                got++;
                if (!hold) ch_valid = ch_valid & ~r;
                if (got == n) ch_valid = '0;
            end
            out_full = rnd_full ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        if (got < n) check("serve_handshake_timeout", 64'(got), 64'(n));
        while (busy && left > 0) begin
            step();
            left--;
            out_full = rnd_full ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        if (busy) check("serve_drain_timeout", 64'(busy), 64'd0);
        out_full = 1'b0;
        repeat (3) step();
    endtask

    task automatic check_round(input string tag);
        check({tag, "_grant_count"}, 64'(gq.size()), 64'(eo.size()));
        eq.delete();
        foreach (eo[i]) begin
            check({tag, "_grant_order"}, (i < gq.size()) ? 64'(gq[i]) : 64'hFFFF, 64'(eo[i]));
            push_exp(eo[i]);
        end
        check({tag, "_word_count"}, 64'(wq.size()), 64'(eq.size()));
        foreach (eq[i]) begin
            if (i < wq.size()) check({tag, "_word"}, 64'(wq[i]), 64'(eq[i]));
        end
        exp_pkts += eo.size();
        check({tag, "_pkt_count"}, 64'(pkt_count), 64'(exp_pkts & 16'hFFFF));
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        out_full = 1'b0;
        ch_valid = '1;
        repeat (2) step();
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_wren", 64'(dout_wren), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_ch_ready", 64'(ch_ready), 64'd0);
        ch_valid = '0;
        rst_n    = 1'b1;
        m_ptr    = 0;
        exp_pkts = 0;
        step();
        clear_q();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        logic [NUM_CH-1:0] mask;
        logic [RES_W-1:0]  d;

        vt[0] = '{0, 2'd1, 3'd1, 3'd1, 80'hABCD123456_0000000000, 1, 48'h48ABCD123456, 48'h0};
        vt[1] = '{4, 2'd2, 3'd3, 3'd2, 80'h0123456789_ABCDEF0011, 2, 48'h990123456789, 48'h9AABCDEF0011};
        vt[2] = '{2, 2'd1, 3'd0, 3'd0, 80'hFEDCBA9876_5432101234, 1, 48'h40FEDCBA9876, 48'h0};
        vt[3] = '{3, 2'd2, 3'd5, 3'd5, 80'h1111111111_2222222222, 2, 48'hA91111111111, 48'hAA2222222222};
        vt[4] = '{5, 2'd3, 3'd7, 3'd7, 80'hCAFEBABE00_DEADBEEF55, 2, 48'hF9CAFEBABE00, 48'hFADEADBEEF55};
        vt[5] = '{1, 2'd0, 3'd2, 3'd1, 80'h0000000001_FFFFFFFFFF, 1, 48'h100000000001, 48'h0};

        do_reset();

        // Single packets from the vector table
        foreach (vt[i]) begin
            clear_q();
            arm(vt[i].ch, vt[i].data, vt[i].app, vt[i].size, vt[i].len);
            serve(1, 1'b0, 1'b0);
            check("vec_grant", (gq.size() == 1) ? 64'(gq[0]) : 64'hFFFF, 64'(vt[i].ch));
            check("vec_word_count", 64'(wq.size()), 64'(vt[i].nw));
            if (wq.size() > 0) check("vec_word0", 64'(wq[0]), 64'(vt[i].w0));
            if (vt[i].nw == 2 && wq.size() > 1) begin
                check("vec_word1", 64'(wq[1]), 64'(vt[i].w1));
                check("vec_back_to_back", 64'(wc[1] - wc[0]), 64'd1);
            end
            if (wq.size() > 0 && gc.size() > 0) check("vec_latency", 64'(wc[0] - gc[0]), 64'd2);
            exp_pkts++;
            check("vec_pkt_count", 64'(pkt_count), 64'(exp_pkts));
            m_ptr = (vt[i].ch + 1) % NUM_CH;
        end

        // Backpressure for three cycles after beat 1
        clear_q();
        arm(4, 80'h0123456789_ABCDEF0011, 2'd2, 3'd3, 3'd2);
        k = 0;
        do begin @(negedge clk); k++; end while (ch_ready == '0 && k < 20);
        step();
        ch_valid = '0;
        k = 0;
        while (!dout_wren && k < 20) begin step(); k++; end
        check("bp_first_beat_seen", 64'(dout_wren), 64'd1);
        out_full = 1'b1;
        repeat (3) step();
        out_full = 1'b0;
        repeat (4) step();
        check("bp_word_count", 64'(wq.size()), 64'd2);
        if (wq.size() > 1) begin
            check("bp_word0", 64'(wq[0]), 64'h990123456789);
            check("bp_word1", 64'(wq[1]), 64'h9AABCDEF0011);
            check("bp_gap", 64'(wc[1] - wc[0]), 64'd4);
        end
        exp_pkts++;
        m_ptr = 5;
        check("bp_pkt_count", 64'(pkt_count), 64'(exp_pkts));

        // Round robin from a fresh pointer
        do_reset();
        arm(1, 80'h1010101010_1111111111, 2'd1, 3'd1, 3'd2);
        arm(3, 80'h3030303030_3333333333, 2'd2, 3'd2, 3'd1);
        arm(5, 80'h5050505050_5555555555, 2'd3, 3'd3, 3'd2);
        model_order(6'b101010, 3, 1'b1);
        serve(3, 1'b0, 1'b0);
        check_round("rr_135");
        if (gq.size() == 3) check("rr_last_is_5", 64'(gq[2]), 64'd5);

        clear_q();
        arm(5, 80'h5A5A5A5A5A_A5A5A5A5A5, 2'd2, 3'd4, 3'd1);
        arm(1, 80'h1A1A1A1A1A_A1A1A1A1A1, 2'd1, 3'd6, 3'd2);
        model_order(6'b100010, 2, 1'b1);
        serve(2, 1'b0, 1'b0);
        check_round("rr_15");
        if (gq.size() > 0) check("rr_wrap_first_is_1", 64'(gq[0]), 64'd1);

        clear_q();
        arm(0, 80'h0F0F0F0F0F_F0F0F0F0F0, 2'd1, 3'd0, 3'd1);
        arm(2, 80'h2222222222_2F2F2F2F2F, 2'd2, 3'd1, 3'd2);
        model_order(6'b000101, 6, 1'b0);
        serve(6, 1'b1, 1'b0);
        check_round("rr_alternate");

        // Randomized rounds with random backpressure
        for (int r = 0; r < 12; r++) begin
            clear_q();
            mask = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
            for (int c = 0; c < NUM_CH; c++) begin
                if (mask[c]) begin
                    d = RES_W'({$urandom(), $urandom(), $urandom()});
                    arm(c, d, 2'($urandom()), 3'($urandom()), 3'($urandom()));
                end
            end
            model_order(mask, $countones(mask), 1'b1);
            serve($countones(mask), 1'b0, 1'b1);
            check_round("rand");
        end

        // Reset in the middle of a two-beat packet
        clear_q();
        arm(4, 80'h0123456789_ABCDEF0011, 2'd2, 3'd3, 3'd2);
        k = 0;
        do begin @(negedge clk); k++; end while (ch_ready == '0 && k < 20);
        step();
        ch_valid = '0;
        k = 0;
        while (!dout_wren && k < 20) begin step(); k++; end
        rst_n    = 1'b0;
        ch_valid = '1;
        #1;
        check("midrst_dout", 64'(dout), 64'd0);
        check("midrst_wren", 64'(dout_wren), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_pkt_count", 64'(pkt_count), 64'd0);
        check("midrst_ch_ready", 64'(ch_ready), 64'd0);
        repeat (2) step();
        ch_valid = '0;
        rst_n    = 1'b1;
        clear_q();
        repeat (6) step();
        check("midrst_no_late_beat", 64'(wq.size()), 64'd0);
        check("midrst_pkt_count_after", 64'(pkt_count), 64'd0);
        check("midrst_idle_after", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
